toy_ext_intr_hub: RTL and testbench

TOY_EXT_INTR_HUB -- requirements
Module: toy_ext_intr_hub

---
 rtl/toy_ext_intr_hub.sv | 128 ++++++++++++
 tb/tb_toy_ext_intr_hub.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_ext_intr_hub.sv
// External interrupt hub: per-channel edge/level pending capture, fixed-priority
// (lowest index) arbitration and a REQ/SERV handshake. Define TOY_INTR_SYNC_EN for input synchronizers.
module toy_ext_intr_hub #(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] intr_raw,
    input  logic [NUM_CH-1:0] intr_mode,
    input  logic [NUM_CH-1:0] intr_en,
    input  logic              debug_stepie_mask,
    output logic              intr_vld,
    output logic [ID_W-1:0]   intr_id,
    input  logic              intr_rdy,
    input  logic              intr_clr,
    input  logic [ID_W-1:0]   intr_clr_id,
    output logic [NUM_CH-1:0] intr_pend
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] h_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] edge_det;
    logic [NUM_CH-1:0] clr_hit;
    logic [NUM_CH-1:0] cand;
    logic              any_cand;
    logic [ID_W-1:0]   low_id;

`ifdef TOY_INTR_SYNC_EN
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

    // NOTE: every synchronizer stage is reset so a held-high line is seen as a fresh edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= intr_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    // SYNC_STAGES only shapes the synchronizer build.
    logic unused_sync_stages;
    assign unused_sync_stages = (SYNC_STAGES != 0);
    assign s = intr_raw;
`endif

    // Out-of-range clear ids match no channel and therefore do nothing.
    always_comb begin
        clr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clr_hit[i] = intr_clr && (intr_clr_id == ID_W'(i));
        end
    end

    // Edge channels: a new edge beats a same-cycle clear. Level channels follow s.
    assign edge_det = s & ~h_q;
    assign pend_d   = (intr_mode & (edge_det | (pend_q & ~clr_hit))) | (~intr_mode & s);

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q    <= '0;
            pend_q <= '0;
        end else begin
            h_q    <= s;
            pend_q <= pend_d;
        end
    end

    assign cand = pend_q & intr_en;

    // NOTE: defaults come first in every combinational block so no path infers a latch.
    always_comb begin
        any_cand = |cand;
        low_id   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) low_id = ID_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (debug_stepie_mask && any_cand) begin
                    state_d = REQ;
                    id_d    = low_id;
                end
            end
            REQ: begin
                if (intr_rdy) state_d = SERV;
            end
            SERV: begin
                if (intr_clr && (intr_clr_id == id_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    assign intr_vld  = (state_q == REQ);
    assign intr_id   = id_q;
    assign intr_pend = pend_q;

endmodule

// File: tb/tb_toy_ext_intr_hub.sv
// Self-checking bench for toy_ext_intr_hub: directed scenarios plus randomized
// traffic, all compared against a behavioural reference model.
module tb_toy_ext_intr_hub;

    localparam int NUM_CH      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ID_W        = $clog2(NUM_CH);
`ifdef TOY_INTR_SYNC_EN
    localparam int DLY = SYNC_STAGES;
`else
    localparam int DLY = 0;
`endif
    localparam int LAT = DLY + 1;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_SERV = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] intr_raw;
    logic [NUM_CH-1:0] intr_mode;
    logic [NUM_CH-1:0] intr_en;
    logic              debug_stepie_mask;
    logic              intr_vld;
    logic [ID_W-1:0]   intr_id;
    logic              intr_rdy;
    logic              intr_clr;
    logic [ID_W-1:0]   intr_clr_id;
    logic [NUM_CH-1:0] intr_pend;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [NUM_CH-1:0] rh[$];
    logic [NUM_CH-1:0] m_pend;
    int                m_phase;
    int                m_id;

    toy_ext_intr_hub #(
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(SYNC_STAGES),
        .ID_W       (ID_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .intr_raw         (intr_raw),
        .intr_mode        (intr_mode),
        .intr_en          (intr_en),
        .debug_stepie_mask(debug_stepie_mask),
        .intr_vld         (intr_vld),
        .intr_id          (intr_id),
        .intr_rdy         (intr_rdy),
        .intr_clr         (intr_clr),
        .intr_clr_id      (intr_clr_id),
        .intr_pend        (intr_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] raw_at(input int back);
        int idx;
        idx = rh.size() - 1 - back;
        return (idx < 0) ? '0 : rh[idx];
    endfunction

    function automatic int lowest(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        rh.delete();
        m_pend  = '0;
        m_phase = P_IDLE;
        m_id    = 0;
    endtask

    // One rising edge of the reference: s is the raw line DLY edges ago, history one edge older.
    task automatic model_edge();
        logic [NUM_CH-1:0] s_now, s_old, rose, clr_vec, next_pend, cand;
        rh.push_back(intr_raw);
        if (rh.size() > 8) void'(rh.pop_front());
        s_now   = raw_at(DLY);
        s_old   = raw_at(DLY + 1);
        rose    = s_now & ~s_old;
        clr_vec = '0;
        if (intr_clr && (int'(intr_clr_id) < NUM_CH)) clr_vec[intr_clr_id] = 1'b1;
        next_pend = (intr_mode & (rose | (m_pend & ~clr_vec))) | (~intr_mode & s_now);
        cand = m_pend & intr_en;
        if (m_phase == P_IDLE) begin
            if (debug_stepie_mask && cand != '0) begin
                m_phase = P_REQ;
                m_id    = lowest(cand);
            end
        end else if (m_phase == P_REQ) begin
            if (intr_rdy) m_phase = P_SERV;
        end else begin
            if (intr_clr && int'(intr_clr_id) == m_id) m_phase = P_IDLE;
        end
        m_pend = next_pend;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("vld", {31'd0, intr_vld}, {31'd0, m_phase == P_REQ});
        if (m_phase != P_IDLE) check("id", 32'(intr_id), 32'(m_id));
        check("pend", 32'(intr_pend), 32'(m_pend));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Assert reset a little after a falling edge, check outputs at once, release on the next falling edge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_vld", {31'd0, intr_vld}, 32'd0);
        check("rst_id", 32'(intr_id), 32'd0);
        check("rst_pend", 32'(intr_pend), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic serve(input int id);
        intr_rdy = 1'b1;
        step();
        intr_rdy    = 1'b0;
        intr_clr    = 1'b1;
        intr_clr_id = ID_W'(id);
        step();
        intr_clr = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        intr_raw          = '0;
        intr_mode         = '1;
        intr_en           = '1;
        debug_stepie_mask = 1'b1;
        intr_rdy          = 1'b0;
        intr_clr          = 1'b0;
        intr_clr_id       = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_vld", {31'd0, intr_vld}, 32'd0);
        check("reset_id", 32'(intr_id), 32'd0);
        check("reset_pend", 32'(intr_pend), 32'd0);
        rst_n = 1'b1;
        step();

        // edge ch3: pend after LAT edges, request one edge later; then hold while ch0 pends
        intr_raw = 8'h08;
        steps(LAT);
        check("lat_pend3", {31'd0, intr_pend[3]}, 32'd1);
        check("lat_vld_early", {31'd0, intr_vld}, 32'd0);
        step();
        check("lat_vld", {31'd0, intr_vld}, 32'd1);
        check("lat_id", 32'(intr_id), 32'd3);
        intr_raw = 8'h09;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_id", 32'(intr_id), 32'd3);
            check("hold_vld", {31'd0, intr_vld}, 32'd1);
        end
        serve(3);
        step();
        check("next_id0", 32'(intr_id), 32'd0);
        serve(0);
        intr_raw = '0;
        steps(LAT + 1);

        // ch1 and ch5 together: lowest first, ch5 requests two edges after the clear
        intr_raw = 8'h22;
        steps(LAT + 1);
        check("prio_id1", 32'(intr_id), 32'd1);
        intr_rdy = 1'b1;
        step();
        intr_rdy    = 1'b0;
        intr_clr    = 1'b1;
        intr_clr_id = 3'd1;
        step();
        intr_clr = 1'b0;
        check("b2b_gap", {31'd0, intr_vld}, 32'd0);
        step();
        check("b2b_vld", {31'd0, intr_vld}, 32'd1);
        check("b2b_id5", 32'(intr_id), 32'd5);
        serve(5);
        intr_raw = '0;
        steps(LAT + 1);

        // ch2: clear coincides with a new edge detection, set wins
        intr_raw = 8'h04;
        steps(LAT + 1);
        intr_rdy = 1'b1;
        step();
        intr_rdy = 1'b0;
        intr_raw = '0;
        steps(LAT + 1);
        intr_raw = 8'h04;
        steps(LAT - 1);
        intr_clr    = 1'b1;
        intr_clr_id = 3'd2;
        step();
        intr_clr = 1'b0;
        check("setwins_pend2", {31'd0, intr_pend[2]}, 32'd1);
        step();
        check("setwins_vld", {31'd0, intr_vld}, 32'd1);
        check("setwins_id", 32'(intr_id), 32'd2);
        serve(2);
        intr_raw = '0;
        steps(LAT + 1);

        // level ch4 under global mask
        intr_mode         = 8'hEF;
        debug_stepie_mask = 1'b0;
        intr_raw          = 8'h10;
        steps(LAT + 2);
        check("lvl_pend4", {31'd0, intr_pend[4]}, 32'd1);
        check("lvl_masked", {31'd0, intr_vld}, 32'd0);
        debug_stepie_mask = 1'b1;
        step();
        check("lvl_vld", {31'd0, intr_vld}, 32'd1);
        check("lvl_id", 32'(intr_id), 32'd4);
        intr_raw = '0;
        steps(LAT);
        check("lvl_drop", {31'd0, intr_pend[4]}, 32'd0);
        check("lvl_still_vld", {31'd0, intr_vld}, 32'd1);
        serve(4);
        intr_mode = '1;
        step();

        // reset during SERV with ch6 held high
        intr_raw = 8'h40;
        steps(LAT + 1);
        intr_rdy = 1'b1;
        step();
        intr_rdy = 1'b0;
        pulse_reset();
        steps(LAT);
        check("rst_redetect_pend", {31'd0, intr_pend[6]}, 32'd1);
        step();
        check("rst_redetect_id", 32'(intr_id), 32'd6);
        check("rst_redetect_vld", {31'd0, intr_vld}, 32'd1);
        serve(6);
        intr_raw = '0;
        steps(LAT + 1);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) intr_mode = NUM_CH'($urandom);
            if (c % 20 == 0) intr_en = NUM_CH'($urandom);
            intr_raw          = intr_raw ^ NUM_CH'($urandom & $urandom & $urandom);
            debug_stepie_mask = ($urandom_range(0, 7) != 0);
            intr_rdy          = $urandom_range(0, 1) != 0;
            intr_clr          = $urandom_range(0, 3) == 0;
            intr_clr_id       = ($urandom_range(0, 1) != 0) ? ID_W'(m_id) : ID_W'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
